// File: rtl/sum_diff_compare_pkg.sv
// Shared constants and types for the sum/difference compare pipeline.
package sum_diff_compare_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int STATS_W       = 16;

  typedef logic [STATS_W-1:0] stat_cnt_t;

  // Saturating increment: sticks at all-ones instead of wrapping to zero.
  function automatic stat_cnt_t sat_inc(input stat_cnt_t v);
    if (v == {STATS_W{1'b1}}) begin
      return v;
    end else begin
      return v + stat_cnt_t'(1'b1);
    end
  endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// Generic valid/ready register slice. The slice accepts new data whenever it
// is empty or its current contents leave in the same cycle.
module pipe_reg_stage
  import sum_diff_compare_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_N,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Next state: load on an input transfer, drop valid when drained.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
    end else begin
      valid_d = valid_q;
    end
    if (in_valid && in_ready) begin
      data_d = in_data;
    end else begin
      data_d = data_q;
    end
  end

  // Slice registers; reset clears both valid and payload.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      valid_q <= 1'b0;
      data_q  <= {W{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/sum_diff_compare_pipe.sv
// Two-stage pipelined (a + b) < (c - d) with valid/ready handshakes.
// Stage 1 registers sum, difference and overflow; stage 2 registers the
// compare result alongside the forwarded values.
// Optional statistics counters: define SUM_DIFF_COMPARE_STATS_EN.
module sum_diff_compare_pipe
  import sum_diff_compare_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int WRAP  = 0
) (
  input  logic             clock,
  input  logic             reset_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out,
  output logic [WIDTH:0]   sum_out,
  output logic [WIDTH:0]   diff_out,
  output logic             ovf
`ifdef SUM_DIFF_COMPARE_STATS_EN
  ,
  input  logic             stats_clear,
  output logic [STATS_W-1:0] acc_count,
  output logic [STATS_W-1:0] true_count
`endif
);

  localparam int SW  = WIDTH + 1;
  localparam int P1W = 2 * SW + 1;
  localparam int P2W = 2 * SW + 2;

  // Holds in_ready low until the first clock edge after reset release.
  logic rdy_en_q, rdy_en_d;

  logic [SW-1:0]  sum_full_s, diff_full_s, sum1_s, diff1_s;
  logic           ovf1_s;
  logic [P1W-1:0] p1_in_s, p1_out_s;
  logic [SW-1:0]  sum1_q, diff1_q;
  logic           ovf1_q;
  logic           cmp_s;
  logic [P2W-1:0] p2_in_s, p2_out_s;
  logic           s1_valid_s, s1_ready_s, s2_ready_s;

  // Ready-enable comes up one edge after reset deasserts.
  always_comb begin
    rdy_en_d = 1'b1;
  end

  // Ready-enable register.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= rdy_en_d;
    end
  end

  assign in_ready = rdy_en_q && s1_ready_s;

  // Stage 1 arithmetic; overflow is taken from the full-width results
  // even when the stored values are truncated.
  always_comb begin
    sum_full_s  = {1'b0, a} + {1'b0, b};
    diff_full_s = {1'b0, c} - {1'b0, d};
    ovf1_s      = sum_full_s[WIDTH] | (c < d);
    if (WRAP != 0) begin
      sum1_s  = {1'b0, sum_full_s[WIDTH-1:0]};
      diff1_s = {1'b0, diff_full_s[WIDTH-1:0]};
    end else begin
      sum1_s  = sum_full_s;
      diff1_s = diff_full_s;
    end
  end

  assign p1_in_s = {ovf1_s, diff1_s, sum1_s};

  pipe_reg_stage #(.W(P1W)) u_stage1 (
    .clock     (clock),
    .reset_N   (reset_N),
    .in_valid  (in_valid && rdy_en_q),
    .in_ready  (s1_ready_s),
    .in_data   (p1_in_s),
    .out_valid (s1_valid_s),
    .out_ready (s2_ready_s),
    .out_data  (p1_out_s)
  );

  assign {ovf1_q, diff1_q, sum1_q} = p1_out_s;

  // Stage 2 compare: exact mode is a signed compare one bit wider than the
  // stored values so a negative difference never wins; wrap mode is a plain
  // unsigned compare of the truncated values.
  always_comb begin
    cmp_s = 1'b0;
    if (WRAP != 0) begin
      cmp_s = sum1_q[WIDTH-1:0] < diff1_q[WIDTH-1:0];
    end else begin
      cmp_s = $signed({1'b0, sum1_q}) < $signed({diff1_q[WIDTH], diff1_q});
    end
  end

  assign p2_in_s = {cmp_s, ovf1_q, diff1_q, sum1_q};

  pipe_reg_stage #(.W(P2W)) u_stage2 (
    .clock     (clock),
    .reset_N   (reset_N),
    .in_valid  (s1_valid_s),
    .in_ready  (s2_ready_s),
    .in_data   (p2_in_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (p2_out_s)
  );

  assign {out, ovf, diff_out, sum_out} = p2_out_s;

`ifdef SUM_DIFF_COMPARE_STATS_EN
  stat_cnt_t acc_q, acc_d, true_q, true_d;
  logic      out_xfer_s;

  assign out_xfer_s = out_valid && out_ready;
  assign acc_count  = acc_q;
  assign true_count = true_q;

  // Counter update; clear wins over a same-cycle increment.
  always_comb begin
    acc_d  = acc_q;
    true_d = true_q;
    if (stats_clear) begin
      acc_d  = {STATS_W{1'b0}};
      true_d = {STATS_W{1'b0}};
    end else if (out_xfer_s) begin
      acc_d = sat_inc(acc_q);
      if (out) begin
        true_d = sat_inc(true_q);
      end else begin
        true_d = true_q;
      end
    end else begin
      acc_d  = acc_q;
      true_d = true_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      acc_q  <= {STATS_W{1'b0}};
      true_q <= {STATS_W{1'b0}};
    end else begin
      acc_q  <= acc_d;
      true_q <= true_d;
    end
  end
`endif

endmodule

// File: tb/tb_sum_diff_compare_pipe.sv
// Directed bench for sum_diff_compare_pipe: one WRAP=0 and one WRAP=1
// instance share stimulus; expected values are hand-computed per vector.
module tb_sum_diff_compare_pipe;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] a, b, c, d;
    logic         e0_out;
    logic [W:0]   e0_sum, e0_diff;
    logic         e0_ovf;
    logic         e1_out;
    logic [W:0]   e1_sum, e1_diff;
    logic         e1_ovf;
  } vec_t;

  vec_t vt [10];

  logic clock = 1'b0;
  logic reset_N, in_valid, out_ready, stats_clear;
  logic [W-1:0] a, b, c, d;
  logic in_ready0, out_valid0, out0, ovf0;
  logic in_ready1, out_valid1, out1, ovf1;
  logic [W:0] sum0, diff0, sum1, diff1;
  logic [15:0] acc0, true0, acc1, true1;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  sum_diff_compare_pipe #(.WIDTH(W), .WRAP(0)) u0 (
    .clock(clock), .reset_N(reset_N), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid0), .out_ready(out_ready),
    .out(out0), .sum_out(sum0), .diff_out(diff0), .ovf(ovf0)
`ifdef SUM_DIFF_COMPARE_STATS_EN
    , .stats_clear(stats_clear), .acc_count(acc0), .true_count(true0)
`endif
  );

  sum_diff_compare_pipe #(.WIDTH(W), .WRAP(1)) u1 (
    .clock(clock), .reset_N(reset_N), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid1), .out_ready(out_ready),
    .out(out1), .sum_out(sum1), .diff_out(diff1), .ovf(ovf1)
`ifdef SUM_DIFF_COMPARE_STATS_EN
    , .stats_clear(stats_clear), .acc_count(acc1), .true_count(true1)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare both instances against table entry idx.
  task automatic chk_res(input string tag, input int idx);
    check({tag, " u0.out_valid"}, 32'(out_valid0), 32'd1);
    check({tag, " u0.out"},  32'(out0),  32'(vt[idx].e0_out));
    check({tag, " u0.sum"},  32'(sum0),  32'(vt[idx].e0_sum));
    check({tag, " u0.diff"}, 32'(diff0), 32'(vt[idx].e0_diff));
    check({tag, " u0.ovf"},  32'(ovf0),  32'(vt[idx].e0_ovf));
    check({tag, " u1.out_valid"}, 32'(out_valid1), 32'd1);
    check({tag, " u1.out"},  32'(out1),  32'(vt[idx].e1_out));
    check({tag, " u1.sum"},  32'(sum1),  32'(vt[idx].e1_sum));
    check({tag, " u1.diff"}, 32'(diff1), 32'(vt[idx].e1_diff));
    check({tag, " u1.ovf"},  32'(ovf1),  32'(vt[idx].e1_ovf));
  endtask

  task automatic drive(input int idx);
    a = vt[idx].a; b = vt[idx].b; c = vt[idx].c; d = vt[idx].d;
    in_valid = 1'b1;
  endtask

  // Back-to-back stream of n vectors with out_ready=1: each result must
  // appear exactly two cycles after its acceptance.
  task automatic stream(input int first, input int n);
    for (int t = 0; t < n + 2; t++) begin
      @(negedge clock);
      if (t >= 2) chk_res($sformatf("stream v%0d", first + t - 2), first + t - 2);
      if (t < n) begin
        check("stream in_ready0", 32'(in_ready0), 32'd1);
        check("stream in_ready1", 32'(in_ready1), 32'd1);
        drive(first + t);
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    check({tag, " out_valid0"}, 32'(out_valid0), 32'd0);
    check({tag, " out0"},  32'(out0),  32'd0);
    check({tag, " sum0"},  32'(sum0),  32'd0);
    check({tag, " diff0"}, 32'(diff0), 32'd0);
    check({tag, " ovf0"},  32'(ovf0),  32'd0);
    check({tag, " out_valid1"}, 32'(out_valid1), 32'd0);
    check({tag, " out1"},  32'(out1),  32'd0);
    check({tag, " sum1"},  32'(sum1),  32'd0);
    check({tag, " diff1"}, 32'(diff1), 32'd0);
    check({tag, " ovf1"},  32'(ovf1),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          a      b      c      d     o0    sum0    diff0     v0    o1    sum1    diff1    v1
    vt[0] = '{4'd15, 4'd0,  4'd15, 4'd0,  1'b0, 5'd15, 5'd15,    1'b0, 1'b0, 5'd15, 5'd15, 1'b0};
    vt[1] = '{4'd0,  4'd1,  4'd0,  4'd0,  1'b0, 5'd1,  5'd0,     1'b0, 1'b0, 5'd1,  5'd0,  1'b0};
    vt[2] = '{4'd0,  4'd0,  4'd1,  4'd0,  1'b1, 5'd0,  5'd1,     1'b0, 1'b1, 5'd0,  5'd1,  1'b0};
    vt[3] = '{4'd1,  4'd0,  4'd0,  4'd0,  1'b0, 5'd1,  5'd0,     1'b0, 1'b0, 5'd1,  5'd0,  1'b0};
    vt[4] = '{4'd3,  4'd4,  4'd15, 4'd1,  1'b1, 5'd7,  5'd14,    1'b0, 1'b1, 5'd7,  5'd14, 1'b0};
    vt[5] = '{4'd1,  4'd1,  4'd0,  4'd1,  1'b0, 5'd2,  5'b11111, 1'b1, 1'b1, 5'd2,  5'd15, 1'b1};
    vt[6] = '{4'd5,  4'd6,  4'd10, 4'd9,  1'b0, 5'd11, 5'd1,     1'b0, 1'b0, 5'd11, 5'd1,  1'b0};
    vt[7] = '{4'd15, 4'd15, 4'd15, 4'd0,  1'b0, 5'd30, 5'd15,    1'b1, 1'b1, 5'd14, 5'd15, 1'b1};
    vt[8] = '{4'd0,  4'd0,  4'd0,  4'd15, 1'b0, 5'd0,  5'b10001, 1'b1, 1'b1, 5'd0,  5'd1,  1'b1};
    vt[9] = '{4'd0,  4'd0,  4'd0,  4'd0,  1'b0, 5'd0,  5'd0,     1'b0, 1'b0, 5'd0,  5'd0,  1'b0};

    reset_N = 1'b0; in_valid = 1'b0; out_ready = 1'b1; stats_clear = 1'b0;
    a = '0; b = '0; c = '0; d = '0;

    // Reset state.
    #1;
    chk_zero("reset");
    check("reset in_ready0", 32'(in_ready0), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_N = 1'b1;
    @(posedge clock);
    #1;
    check("post-reset in_ready0", 32'(in_ready0), 32'd1);
    check("post-reset in_ready1", 32'(in_ready1), 32'd1);

    // Full table back-to-back (covers latency, throughput and order).
    stream(0, 10);

    // Backpressure: three sets offered with out_ready low.
    @(negedge clock);
    out_ready = 1'b0;
    check("bp in_ready first", 32'(in_ready0), 32'd1);
    drive(5);
    @(negedge clock);
    check("bp in_ready second", 32'(in_ready0), 32'd1);
    drive(6);
    @(negedge clock);
    drive(7);
    check("bp full in_ready0", 32'(in_ready0), 32'd0);
    check("bp full in_ready1", 32'(in_ready1), 32'd0);
    chk_res("bp hold", 5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
      check("bp stall in_ready", 32'(in_ready0), 32'd0);
      chk_res("bp stable", 5);
    end
    @(negedge clock);
    drive(7);
    out_ready = 1'b1;
    #1;
    check("bp release in_ready0", 32'(in_ready0), 32'd1);
    @(negedge clock);
    in_valid = 1'b0;
    chk_res("bp drain 1", 6);
    @(negedge clock);
    chk_res("bp drain 2", 7);
    @(negedge clock);
    check("bp empty out_valid0", 32'(out_valid0), 32'd0);
    check("bp empty out_valid1", 32'(out_valid1), 32'd0);

    // Reset mid-flight with both stages full.
    out_ready = 1'b0;
    drive(7);
    @(negedge clock);
    drive(4);
    @(negedge clock);
    in_valid = 1'b0;
    check("mid pre out_valid0", 32'(out_valid0), 32'd1);
    #2;
    reset_N = 1'b0;
    #1;
    chk_zero("mid-flight reset");
    @(negedge clock);
    reset_N = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("no stale out_valid0", 32'(out_valid0), 32'd0);
      check("no stale out_valid1", 32'(out_valid1), 32'd0);
    end
    check("mid post in_ready0", 32'(in_ready0), 32'd1);

`ifdef SUM_DIFF_COMPARE_STATS_EN
    @(negedge clock);
    stats_clear = 1'b1;
    @(negedge clock);
    stats_clear = 1'b0;
    check("stats cleared acc0", 32'(acc0), 32'd0);
    stream(2, 3);
    check("stats acc0",  32'(acc0),  32'd3);
    check("stats true0", 32'(true0), 32'd2);
    check("stats acc1",  32'(acc1),  32'd3);
    check("stats true1", 32'(true1), 32'd2);
    @(negedge clock);
    drive(2);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    check("stats pre-clear out_valid0", 32'(out_valid0), 32'd1);
    stats_clear = 1'b1;
    @(negedge clock);
    stats_clear = 1'b0;
    check("stats clr+xfer acc0",  32'(acc0),  32'd0);
    check("stats clr+xfer true0", 32'(true0), 32'd0);
    check("stats clr+xfer out_valid0", 32'(out_valid0), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sum_diff_compare_pipe.md
Name: sum_diff_compare_pipe

Overview:
- Parametrised, pipelined successor of the combinational (a + b) < (c - d) datapath.
- Takes operand sets a, b, c, d on a valid/ready input channel. Delivers the compare result with the intermediate sum and difference on a valid/ready output channel.
- Sits between a stimulus/operand source and a result consumer. Adds configurable width, selectable wrap/exact arithmetic, and overflow reporting.

Parameters:
- WIDTH, 4: operand width in bits (2..32).
- WRAP, 0: 0 = exact arithmetic; 1 = legacy truncated WIDTH-bit arithmetic.

Ports:
- clock  input  1  rising-edge clock
- reset_N  input  1  asynchronous active-low reset
- in_valid  input  1  operand set offered
- in_ready  output  1  block can accept an operand set this cycle
- a, b, c, d  input  WIDTH each  unsigned operands
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out  output  1  compare result
- sum_out  output  WIDTH+1  registered a+b, zero-extended when WRAP=1
- diff_out  output  WIDTH+1  registered c-d, two's complement
- ovf  output  1  a+b carried out of WIDTH bits, or c<d

Behaviour:
- Reset: asynchronous assertion clears both stage valid bits immediately. out_valid=0, out=0, sum_out=0, diff_out=0, ovf=0. in_ready=1 from the first clock edge after deassertion. In-flight data is discarded.
- Stage 1 register: sum = a+b, WIDTH+1 bits. diff = c-d, WIDTH+1-bit signed. ovf1 = sum[WIDTH] | (c<d).
- Stage 2 register: compare result and the forwarded sum/diff/ovf.
- WRAP=0: out = signed compare of {0,sum} < sign-extended diff, at WIDTH+2 bits. A negative diff always gives out=0.
- WRAP=1: sum and diff truncated to WIDTH bits. Unsigned compare. Upper bits of sum_out/diff_out are 0. ovf is still reported.
- Handshake per stage: stage_ready = !stage_valid | next_ready.
  - in_ready = stage1_ready; stage 2's next_ready = out_ready.
  - A transfer occurs when valid & ready are both high at a rising edge.
- Latency: 2 cycles from input acceptance to out_valid with no backpressure. Throughput: 1 per cycle.
- Output stability: while out_valid=1 and out_ready=0, out, sum_out, diff_out and ovf hold stable.
- Full: both stages valid and out_ready=0 → in_ready=0 combinationally in the same cycle. No operand set is lost or duplicated. Order is preserved.
- Simultaneous events: a stage may accept new data in the same cycle it hands data on.
- Operands are sampled only on an input transfer. Changes to a..d while in_ready=0 are ignored.

Optional Feature:
- Macro: SUM_DIFF_COMPARE_STATS_EN.
- When defined, adds ports stats_clear (input, 1), acc_count (output, 16) and true_count (output, 16).
  - acc_count increments on each output transfer.
  - true_count increments on each output transfer with out=1.
  - Both counters saturate at 16'hFFFF.
  - stats_clear synchronously zeroes both counters and has priority over increments in the same cycle.
  - Reset zeroes both counters.
- When not defined: the ports and logic are absent, and datapath behaviour is identical.

Decomposition:
- Package sum_diff_compare_pkg holds:
  - DEFAULT_WIDTH = 4
  - STATS_W = 16
  - a typedef for the saturating counter type
- Sub-module pipe_reg_stage: a generic valid/ready register slice with a parametrised payload width, instantiated twice.

Test Plan:
1. WIDTH=4, WRAP=0: a=15,b=0,c=15,d=0 → after 2 cycles out_valid=1, out=0, sum_out=15, diff_out=15, ovf=0.
2. Back-to-back sets {0,1,0,0}, {0,0,1,0}, {1,0,0,0} with out_ready=1 → out sequence 0, 1, 0 on consecutive cycles starting 2 cycles after the first acceptance.
3. a=1,b=1,c=0,d=1:
   - WRAP=0 → diff_out=5'b11111, out=0, ovf=1.
   - WRAP=1 → diff_out=15, sum_out=2, out=1, ovf=1.
   - a=5,b=6,c=10,d=9 → out=0, sum_out=11, diff_out=1.
4. Backpressure: out_ready=0 while offering 3 sets on consecutive cycles → in_ready drops in the cycle the third set is offered, once both stages are full. out holds stable. After out_ready rises, results emerge in order with none lost.
5. Reset mid-flight: reset_N pulled low with both stages valid → out_valid=0 and all outputs 0 without waiting for a clock edge. After release, no stale result appears.
6. With SUM_DIFF_COMPARE_STATS_EN defined:
   - 3 transfers with out results 1, 0, 1 → acc_count=3, true_count=2.
   - stats_clear asserted in the same cycle as a transfer → both counters read 0.
